serializer: RTL and testbench



---
 rtl/ser_pkg.sv | 16 +
 rtl/serializer.sv | 112 +++++++++++
 tb/tb_serializer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared types and helpers for the serializer.
//   ser_state_t : FSM encoding (IDLE, SEND)
//   ser_len     : maps a bit-count field to a word length, 0 meaning the full width
package ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // A zero count encodes "all bits" so the field never needs an extra bit.
  function automatic int unsigned ser_len(input int unsigned mod, input int unsigned width);
    return (mod == 0) ? width : mod;
  endfunction

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter, one bit per clock with a per-bit valid strobe.
// Optional build macro: SER_LSB_FIRST_EN (LSB first over the N most-significant
// bits; MSB first when undefined). Timing is identical in both builds.
// Ports:
//   clk_i          clock
//   srst_i         synchronous reset, active-high
//   data_i         parallel word to serialize
//   data_mod_i     number of bits to send; 0 means SER_W bits
//   data_val_i     data_i/data_mod_i valid this cycle (ignored while busy)
//   ser_data_o     serial data bit (0 when not valid)
//   ser_data_val_o serial bit valid
//   busy_o         word in progress (equals SEND state)
module serializer
  import ser_pkg::*;
#(
  parameter int unsigned SER_W = 16,
  parameter int unsigned MOD_W = $clog2(SER_W)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [SER_W-1:0] data_i,
  input  logic [MOD_W-1:0] data_mod_i,
  input  logic             data_val_i,
  output logic             ser_data_o,
  output logic             ser_data_val_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = MOD_W + 1;

  ser_state_t       state_q, state_d;
  logic [SER_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ser_data_q, ser_data_d;
  logic             ser_val_q, ser_val_d;

  int unsigned      n_len;
  logic [SER_W-1:0] aligned;

  // State and datapath registers; reset wins over any input activity.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      ser_data_q <= 1'b0;
      ser_val_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      ser_data_q <= ser_data_d;
      ser_val_q  <= ser_val_d;
    end
  end

  // Next-state and output logic. The first bit is produced at the accept
  // cycle so it is registered out one cycle later; cnt_q then holds the
  // number of bits still to send after the one currently on the output.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    ser_data_d = 1'b0;
    ser_val_d  = 1'b0;
    n_len      = ser_len(32'(data_mod_i), SER_W);
`ifdef SER_LSB_FIRST_EN
    // Bring the N most-significant bits down to bit 0 so a right shift walks them upward.
    aligned    = data_i >> (SER_W - n_len);
`else
    aligned    = data_i;
`endif

    case (state_q)
      IDLE: begin
        if (data_val_i) begin
          state_d   = SEND;
          ser_val_d = 1'b1;
          cnt_d     = CNT_W'(n_len - 1);
`ifdef SER_LSB_FIRST_EN
          ser_data_d = aligned[0];
          shift_d    = {1'b0, aligned[SER_W-1:1]};
`else
          ser_data_d = aligned[SER_W-1];
          shift_d    = {aligned[SER_W-2:0], 1'b0};
`endif
        end
      end
      SEND: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          ser_val_d = 1'b1;
          cnt_d     = cnt_q - CNT_W'(1);
`ifdef SER_LSB_FIRST_EN
          ser_data_d = shift_q[0];
          shift_d    = {1'b0, shift_q[SER_W-1:1]};
`else
          ser_data_d = shift_q[SER_W-1];
          shift_d    = {shift_q[SER_W-2:0], 1'b0};
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ser_data_o     = ser_data_q;
  assign ser_data_val_o = ser_val_q;
  assign busy_o         = (state_q == SEND);

endmodule

// File: tb/tb_serializer.sv
// Directed self-checking bench for serializer (SER_W = 16).
// Honours SER_LSB_FIRST_EN to select the expected bit order.
module tb_serializer;

  logic        clk_i;
  logic        srst_i;
  logic [15:0] data_i;
  logic [3:0]  data_mod_i;
  logic        data_val_i;
  logic        ser_data_o;
  logic        ser_data_val_o;
  logic        busy_o;

  int checks;
  int errors;

  serializer #(.SER_W(16)) dut (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .data_i         (data_i),
    .data_mod_i     (data_mod_i),
    .data_val_i     (data_val_i),
    .ser_data_o     (ser_data_o),
    .ser_data_val_o (ser_data_val_o),
    .busy_o         (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

`ifdef SER_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  // Expected bit k of a word is pat[15-k].
  typedef struct {
    logic [15:0] data;
    logic [3:0]  mod;
    int          n;
    logic [15:0] pat_msb;
    logic [15:0] pat_lsb;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".val"}, 16'(ser_data_val_o), 16'h0);
    chk({name, ".data"}, 16'(ser_data_o), 16'h0);
    chk({name, ".busy"}, 16'(busy_o), 16'h0);
  endtask

  task automatic chk_bit(input string name, input logic exp_bit);
    chk({name, ".val"}, 16'(ser_data_val_o), 16'h1);
    chk({name, ".bit"}, 16'(ser_data_o), 16'(exp_bit));
    chk({name, ".busy"}, 16'(busy_o), 16'h1);
  endtask

  // Pulse one word (inputs driven on the falling edge) and check T+1..T+N+1.
  task automatic send_word(input string name, input logic [15:0] d, input logic [3:0] m,
                           input int n, input logic [15:0] pat);
    @(negedge clk_i);
    data_i = d; data_mod_i = m; data_val_i = 1'b1;
    @(negedge clk_i);
    data_val_i = 1'b0;
    data_i = ~d;
    for (int k = 0; k < n; k++) begin
      chk_bit(name, pat[15-k]);
      @(negedge clk_i);
    end
    chk_idle({name, ".end"});
  endtask

  initial begin
    logic [15:0] p1, p2;
    checks = 0;
    errors = 0;
    srst_i = 1'b1;
    data_i = 16'h0;
    data_mod_i = 4'h0;
    data_val_i = 1'b0;

    vecs[0] = '{16'hA5C3, 4'd0, 16, 16'hA5C3, 16'hC3A5};
    vecs[1] = '{16'hE000, 4'd3, 3, 16'hE000, 16'hE000};
    vecs[2] = '{16'h8000, 4'd1, 1, 16'h8000, 16'h8000};
    vecs[3] = '{16'hC000, 4'd4, 4, 16'hC000, 16'h3000};
    vecs[4] = '{16'h1234, 4'd8, 8, 16'h1200, 16'h4800};
    vecs[5] = '{16'hFFFF, 4'd15, 15, 16'hFFFE, 16'hFFFE};
    vecs[6] = '{16'h5AF0, 4'd0, 16, 16'h5AF0, 16'h0F5A};

    // Reset with a pending valid: must stay idle.
    data_val_i = 1'b1;
    data_i = 16'hFFFF;
    repeat (3) @(negedge clk_i);
    chk_idle("reset");
    data_val_i = 1'b0;
    srst_i = 1'b0;
    @(negedge clk_i);
    chk_idle("post_reset");

    foreach (vecs[i]) begin
      send_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].mod, vecs[i].n,
                LSB ? vecs[i].pat_lsb : vecs[i].pat_msb);
    end

    // Ignore while busy: a zero word pulsed at T+5 must not disturb the ones.
    @(negedge clk_i);
    data_i = 16'hFFFF; data_mod_i = 4'd0; data_val_i = 1'b1;
    @(negedge clk_i);
    data_val_i = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk_bit("ignore", 1'b1);
      if (k == 4) begin
        data_i = 16'h0000; data_val_i = 1'b1;
      end else begin
        data_val_i = 1'b0;
      end
      @(negedge clk_i);
    end
    chk_idle("ignore.end");
    @(negedge clk_i);
    chk_idle("ignore.no_second");

    // Back-to-back with data_val_i held high; second accept at T+5.
    p1 = LSB ? 16'h3000 : 16'hC000;
    p2 = LSB ? 16'hC000 : 16'h3000;
    data_i = 16'hC000; data_mod_i = 4'd4; data_val_i = 1'b1;
    @(negedge clk_i);
    data_i = 16'h3000;
    for (int k = 0; k < 4; k++) begin
      chk_bit("b2b.first", p1[15-k]);
      @(negedge clk_i);
    end
    chk_idle("b2b.gap");
    @(negedge clk_i);
    data_val_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk_bit("b2b.second", p2[15-k]);
      @(negedge clk_i);
    end
    chk_idle("b2b.end");

    // Reset at T+6 of a full word, with a simultaneous valid that must lose.
    p1 = LSB ? 16'hC3A5 : 16'hA5C3;
    data_i = 16'hA5C3; data_mod_i = 4'd0; data_val_i = 1'b1;
    @(negedge clk_i);
    data_val_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk_bit("abort.pre", p1[15-k]);
      @(negedge clk_i);
    end
    srst_i = 1'b1;
    data_i = 16'h8000; data_mod_i = 4'd1; data_val_i = 1'b1;
    @(negedge clk_i);
    srst_i = 1'b0;
    data_val_i = 1'b0;
    chk_idle("abort.t7");
    @(negedge clk_i);
    chk_idle("abort.t8");
    send_word("abort.after", 16'h5AF0, 4'd0, 16, LSB ? 16'h0F5A : 16'h5AF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
